// File: rtl/uart_rx_if.sv
// Byte hand-off channel between the UART receiver and the register file.
// The receiver drives the byte and its valid flag; the consumer drives ready.
interface uart_rx_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receive deserialiser: synchronises the pin, validates the start bit, samples
// data mid-bit and delivers good bytes through a one-entry valid/ready holding register.
module uart_rx #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             rx_pin_i,
  input  logic             clr_i,
  uart_rx_if.master        bus,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(4);

  logic             sync_meta_r, rx_sync_r, rx_prev_r;
  logic [1:0]       state_r, state_nxt_s;
  logic [DIV_W-1:0] cnt_r, cnt_nxt_s;
  logic [DIV_W-1:0] divl_r, divl_nxt_s;
  logic [2:0]       bit_idx_r, bit_idx_nxt_s;
  logic [7:0]       shreg_r, shreg_nxt_s;
  logic             busy_r;
  logic             valid_r;
  logic [7:0]       data_r;
  logic             frame_err_r, overrun_r;

  logic             fall_s;
  logic [DIV_W-1:0] half_s;
  logic [DIV_W-1:0] div_clamp_s;
  logic             bit_end_s;
  logic             good_byte_s, bad_byte_s, overrun_set_s, xfer_s;

  assign fall_s      = rx_prev_r & ~rx_sync_r;
  assign half_s      = divl_r >> 1;
  assign div_clamp_s = (div_i < DIV_MIN) ? DIV_MIN : div_i;
  assign bit_end_s   = (cnt_r == (divl_r - CNT_ONE));
  assign xfer_s      = valid_r & bus.rx_ready;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_meta_r <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_prev_r   <= 1'b1;
    end else begin
      sync_meta_r <= rx_pin_i;
      rx_sync_r   <= sync_meta_r;
      rx_prev_r   <= rx_sync_r;
    end
  end

  // Frame FSM next-state logic; the bit counter restarts on every state change.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r + CNT_ONE;
    divl_nxt_s    = divl_r;
    bit_idx_nxt_s = bit_idx_r;
    shreg_nxt_s   = shreg_r;
    good_byte_s   = 1'b0;
    bad_byte_s    = 1'b0;
    if (!en_i) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_nxt_s = CNT_ZERO;
          if (fall_s) begin
            state_nxt_s = START;
            divl_nxt_s  = div_clamp_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: begin
          if (cnt_r == (half_s - CNT_ONE)) begin
            cnt_nxt_s     = CNT_ZERO;
            bit_idx_nxt_s = 3'd0;
            // A line that is high again at mid-start was only a glitch.
            if (!rx_sync_r) begin
              state_nxt_s = DATA;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            cnt_nxt_s   = CNT_ZERO;
            shreg_nxt_s = {rx_sync_r, shreg_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_nxt_s = STOP;
            end else begin
              bit_idx_nxt_s = bit_idx_r + 3'd1;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = IDLE;
            good_byte_s = rx_sync_r;
            bad_byte_s  = ~rx_sync_r;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  assign overrun_set_s = good_byte_s & valid_r & ~bus.rx_ready;

  // Frame FSM state registers; busy is registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      divl_r    <= DIV_MIN;
      bit_idx_r <= 3'd0;
      shreg_r   <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      divl_r    <= divl_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shreg_r   <= shreg_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  // One-entry holding register; a full, unread entry keeps the older byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      data_r  <= 8'h00;
    end else if (good_byte_s && (!valid_r || bus.rx_ready)) begin
      valid_r <= 1'b1;
      data_r  <= shreg_r;
    end else if (xfer_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Sticky error flags; a set event in the clear cycle keeps the flag high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= bad_byte_s | (frame_err_r & ~clr_i);
      overrun_r   <= overrun_set_s | (overrun_r & ~clr_i);
    end
  end

  assign bus.rx_valid = valid_r;
  assign bus.rx_data  = data_r;
  assign frame_err_o  = frame_err_r;
  assign overrun_o    = overrun_r;
  assign busy_o       = busy_r;

endmodule
